kbd_cmd_encoder: RTL and testbench

KBD_CMD_ENCODER -- requirements
Module: kbd_cmd_encoder

---
 rtl/kbd_cmd_encoder.sv | 145 ++++++++++++++
 tb/tb_kbd_cmd_encoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_cmd_encoder.sv
// Turns five level command requests into single ASCII codes on a valid/ready port.
// The kbd value is held for HOLD_CYCLES after acceptance. Define KBD_LOWERCASE_EN for lowercase codes.
module kbd_cmd_encoder #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [7:0]  IDLE_CODE   = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_d,
  input  logic       req_e,
  input  logic       req_b,
  input  logic       req_f,
  input  logic       req_r,
  input  logic       kbd_ready,
  output logic [7:0] kbd,
  output logic       kbd_valid,
  output logic       busy,
  output logic       drop,
  output logic [1:0] state_dbg
);

`ifdef KBD_LOWERCASE_EN
  localparam logic [7:0] CODE_D = 8'h64;
  localparam logic [7:0] CODE_E = 8'h65;
  localparam logic [7:0] CODE_B = 8'h62;
  localparam logic [7:0] CODE_F = 8'h66;
  localparam logic [7:0] CODE_R = 8'h72;
`else
  localparam logic [7:0] CODE_D = 8'h44;
  localparam logic [7:0] CODE_E = 8'h45;
  localparam logic [7:0] CODE_B = 8'h42;
  localparam logic [7:0] CODE_F = 8'h46;
  localparam logic [7:0] CODE_R = 8'h52;
`endif

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Handshake: kbd/kbd_valid are stable while kbd_valid=1; a transfer happens on a
  // rising edge where kbd_valid and kbd_ready are both 1, and kbd_valid drops at that edge.

  // Request bit order: [0]=d, [1]=e, [2]=b, [3]=f, [4]=r
  state_t      state, state_n;
  logic [4:0]  req_q, pending, pending_n;
  logic [4:0]  req_now, press, sel, clr;
  logic [7:0]  cnt, cnt_n;
  logic [7:0]  kbd_r, kbd_n, sel_code;
  logic        drop_r, drop_n;

  assign req_now = {req_r, req_f, req_b, req_e, req_d};
  assign press   = req_now & ~req_q;

  // Fixed priority R > D > E > F > B
  always_comb begin
    sel      = 5'b00000;
    sel_code = IDLE_CODE;
    if (pending[4]) begin
      sel = 5'b10000; sel_code = CODE_R;
    end else if (pending[0]) begin
      sel = 5'b00001; sel_code = CODE_D;
    end else if (pending[1]) begin
      sel = 5'b00010; sel_code = CODE_E;
    end else if (pending[3]) begin
      sel = 5'b01000; sel_code = CODE_F;
    end else if (pending[2]) begin
      sel = 5'b00100; sel_code = CODE_B;
    end
  end

  always_comb begin
    state_n = state;
    kbd_n   = kbd_r;
    cnt_n   = cnt;
    clr     = 5'b00000;
    case (state)
      IDLE: begin
        kbd_n = IDLE_CODE;
        if (|pending) begin
          state_n = PRESENT;
          kbd_n   = sel_code;
          clr     = sel;
        end
      end
      PRESENT: begin
        if (kbd_ready) begin
          if (HOLD_LOAD == 8'd0) begin
            state_n = IDLE;
            kbd_n   = IDLE_CODE;
          end else begin
            state_n = HOLD;
            cnt_n   = HOLD_LOAD;
          end
        end
      end
      HOLD: begin
        // Counter stops at zero; the last hold cycle is the one with cnt==1
        if (cnt <= 8'd1) begin
          state_n = IDLE;
          kbd_n   = IDLE_CODE;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        kbd_n   = IDLE_CODE;
        cnt_n   = 8'd0;
      end
    endcase
    // A flag cleared this cycle may be re-armed by a press without counting as a drop
    drop_n    = |(press & pending & ~clr);
    pending_n = (pending & ~clr) | press;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      req_q   <= 5'b11111;
      pending <= 5'b00000;
      cnt     <= 8'd0;
      kbd_r   <= IDLE_CODE;
      drop_r  <= 1'b0;
    end else begin
      state   <= state_n;
      req_q   <= req_now;
      pending <= pending_n;
      cnt     <= cnt_n;
      kbd_r   <= kbd_n;
      drop_r  <= drop_n;
    end
  end

  assign kbd       = kbd_r;
  assign kbd_valid = (state == PRESENT);
  assign busy      = (state != IDLE);
  assign drop      = drop_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_kbd_cmd_encoder.sv
// Bench for kbd_cmd_encoder: directed scenarios then random requests, all checked
// against a command-level reference model (pending set, offered command, hold time left).
module tb_kbd_cmd_encoder;

  localparam int HOLD = 4;

`ifdef KBD_LOWERCASE_EN
  localparam logic [7:0] C_D = 8'h64, C_E = 8'h65, C_B = 8'h62, C_F = 8'h66, C_R = 8'h72;
`else
  localparam logic [7:0] C_D = 8'h44, C_E = 8'h45, C_B = 8'h42, C_F = 8'h46, C_R = 8'h52;
`endif

  // clock/reset and stimulus
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] reqv = 5'b00000;   // [0]=d [1]=e [2]=b [3]=f [4]=r
  logic       kbd_ready = 1'b1;
  logic       req_d, req_e, req_b, req_f, req_r;
  logic [7:0] kbd;
  logic       kbd_valid, busy, drop;
  logic [1:0] state_dbg;

  assign req_d = reqv[0];
  assign req_e = reqv[1];
  assign req_b = reqv[2];
  assign req_f = reqv[3];
  assign req_r = reqv[4];

  always #5 clk = ~clk;

  kbd_cmd_encoder #(.HOLD_CYCLES(HOLD), .IDLE_CODE(8'h00)) dut (
    .clk(clk), .reset(reset),
    .req_d(req_d), .req_e(req_e), .req_b(req_b), .req_f(req_f), .req_r(req_r),
    .kbd_ready(kbd_ready), .kbd(kbd), .kbd_valid(kbd_valid),
    .busy(busy), .drop(drop), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // reference model
  logic [7:0] code_of [5];
  int         prio [5];
  bit         m_pend [5];
  bit         m_prev [5];
  bit         m_offered;
  int         m_hold_left;
  int         m_cur;       // -1: no command on kbd
  bit         m_drop;
  logic [7:0] exp_q [$];   // codes expected to be accepted, in order
  int         drop_seen;

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) begin
      m_pend[i] = 0;
      m_prev[i] = 1;
    end
    m_offered = 0;
    m_hold_left = 0;
    m_cur = -1;
    m_drop = 0;
  endfunction

  function automatic void model_step(input logic [4:0] r, input logic rdy);
    bit press [5];
    int cleared;
    cleared = -1;
    for (int i = 0; i < 5; i++) press[i] = r[i] && !m_prev[i];
    if (m_offered) begin
      if (rdy) begin
        m_offered = 0;
        if (HOLD == 0) m_cur = -1;
        else m_hold_left = HOLD;
      end
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) m_cur = -1;
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (cleared < 0 && m_pend[prio[k]]) cleared = prio[k];
      end
      if (cleared >= 0) begin
        m_offered = 1;
        m_cur = int'(code_of[cleared]);
        m_pend[cleared] = 0;
      end
    end
    m_drop = 0;
    for (int i = 0; i < 5; i++) begin
      if (press[i] && m_pend[i]) m_drop = 1;
      if (press[i]) m_pend[i] = 1;
      m_prev[i] = r[i];
    end
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] ek;
    ek = (m_cur < 0) ? 8'h00 : m_cur[7:0];
    check({tag, "_kbd"},   kbd, ek);
    check({tag, "_valid"}, {7'd0, kbd_valid}, {7'd0, m_offered});
    check({tag, "_busy"},  {7'd0, busy}, {7'd0, (m_offered || m_hold_left > 0)});
    check({tag, "_drop"},  {7'd0, drop}, {7'd0, m_drop});
  endtask

  // one clock: model advances with the inputs seen at the edge, outputs checked 1ns later
  task automatic step(input string tag);
    @(posedge clk);
    if (reset) model_reset();
    else begin
      if (m_offered && kbd_ready) exp_q.push_back(m_cur[7:0]);
      model_step(reqv, kbd_ready);
    end
    #1;
    if (drop) drop_seen++;
    check_all(tag);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    steps("rst_hold", 2);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    code_of[0] = C_D; code_of[1] = C_E; code_of[2] = C_B; code_of[3] = C_F; code_of[4] = C_R;
    prio[0] = 4; prio[1] = 0; prio[2] = 1; prio[3] = 3; prio[4] = 2;
    model_reset();
    drop_seen = 0;

    // reset state
    #2;
    check_all("reset");
    steps("rst_hold", 2);
    @(negedge clk);
    reset = 1'b0;
    steps("idle", 2);

    // single press of E with ready high
    @(negedge clk); reqv[1] = 1'b1;
    step("e_press");
    check("e_not_yet_valid", {7'd0, kbd_valid}, 8'd0);
    step("e_present");
    check("e_code", kbd, C_E);
    check("e_valid", {7'd0, kbd_valid}, 8'd1);
    for (int i = 0; i < HOLD; i++) begin
      step("e_hold");
      check("e_hold_code", kbd, C_E);
    end
    step("e_idle");
    check("e_idle_code", kbd, 8'h00);
    @(negedge clk); reqv[1] = 1'b0;
    steps("e_rel", 2);

    // simultaneous B, F, R: served R, F, B
    exp_q.delete();
    @(negedge clk); reqv[2] = 1'b1; reqv[3] = 1'b1; reqv[4] = 1'b1;
    steps("sim", 3 * (HOLD + 2) + 3);
    check("sim_count", 8'(exp_q.size()), 8'd3);
    if (exp_q.size() == 3) begin
      check("sim_first", exp_q[0], C_R);
      check("sim_second", exp_q[1], C_F);
      check("sim_third", exp_q[2], C_B);
    end
    @(negedge clk); reqv = 5'b00000;
    steps("sim_rel", 2);

    // backpressure on D for 10 cycles
    @(negedge clk); kbd_ready = 1'b0; reqv[0] = 1'b1;
    steps("bp_press", 2);
    for (int i = 0; i < 10; i++) begin
      step("bp_stall");
      check("bp_code", kbd, C_D);
    end
    @(negedge clk); kbd_ready = 1'b1;
    step("bp_accept");
    check("bp_valid_low", {7'd0, kbd_valid}, 8'd0);
    steps("bp_hold", HOLD + 2);
    @(negedge clk); reqv[0] = 1'b0;
    steps("bp_rel", 1);

    // duplicate D presses while stalled
    exp_q.delete();
    drop_seen = 0;
    @(negedge clk); kbd_ready = 1'b0; reqv[0] = 1'b1;
    steps("dup", 3);
    for (int p = 0; p < 2; p++) begin
      @(negedge clk); reqv[0] = 1'b0;
      step("dup_lo");
      @(negedge clk); reqv[0] = 1'b1;
      steps("dup_hi", 2);
    end
    @(negedge clk); kbd_ready = 1'b1; reqv[0] = 1'b0;
    steps("dup_drain", 2 * (HOLD + 2) + 4);
    check("dup_drops", 8'(drop_seen), 8'd1);
    check("dup_served", 8'(exp_q.size()), 8'd2);

    // reset two cycles into HOLD, R held high through release
    @(negedge clk); reqv[4] = 1'b1;
    steps("rh", 4);
    check("rh_in_hold", {7'd0, busy}, 8'd1);
    apply_reset();
    check("rh_kbd_after", kbd, 8'h00);
    steps("rh_after", 6);
    check("rh_no_cmd", {7'd0, busy}, 8'd0);
    @(negedge clk); reqv = 5'b00000;
    steps("rh_rel", 2);

    // randomized requests and backpressure
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 5) == 0) reqv[i] = ~reqv[i];
      kbd_ready = ($urandom_range(0, 3) != 0);
      if (c == 300) apply_reset();
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
